// File: rtl/speed_switch_requester_pkg.sv
// speed_switch_requester_pkg: KEY1 address, prepare value and handshake state encoding
package speed_switch_requester_pkg;
   localparam logic [15:0] KEY1_ADDR = 16'hFF4D;
   localparam logic [7:0] KEY1_PREPARE = 8'h01;
   typedef enum logic [2:0] {
      IDLE,
      ISSUE_WR,
      WAIT_ASSERT,
      WAIT_DEASSERT,
      DONE,
      FAIL,
      STOPPED
   } state_e;
endpackage

// File: rtl/speed_switch_requester_if.sv
// speed_switch_requester_if: CPU snoop, handshake and IO-bus master signals of the speed-switch requester
interface speed_switch_requester_if;
   logic [15:0] I_CPU_ADDR;
   logic [7:0] I_CPU_WDATA;
   logic I_CPU_WE_L;
   logic I_STOP_REQ;
   logic I_JOYPAD_WAKE;
   logic I_DISABLE_CONTROLLER;
   logic O_BUS_OWN;
   logic [15:0] O_IOREG_ADDR;
   logic [7:0] O_IOREG_DATA;
   logic O_IOREG_WE_L;
   logic O_CPU_STALL;
   logic O_ARMED;
   logic O_SWITCH_DONE;
   logic O_TIMEOUT_ERR;
   modport slave (
      input I_CPU_ADDR, I_CPU_WDATA, I_CPU_WE_L, I_STOP_REQ, I_JOYPAD_WAKE, I_DISABLE_CONTROLLER,
      output O_BUS_OWN, O_IOREG_ADDR, O_IOREG_DATA, O_IOREG_WE_L, O_CPU_STALL, O_ARMED,
      O_SWITCH_DONE, O_TIMEOUT_ERR
   );
   modport master (
      output I_CPU_ADDR, I_CPU_WDATA, I_CPU_WE_L, I_STOP_REQ, I_JOYPAD_WAKE, I_DISABLE_CONTROLLER,
      input O_BUS_OWN, O_IOREG_ADDR, O_IOREG_DATA, O_IOREG_WE_L, O_CPU_STALL, O_ARMED,
      O_SWITCH_DONE, O_TIMEOUT_ERR
   );
endinterface

// File: rtl/speed_switch_requester_sync_2ff.sv
// sync_2ff: generic 1-bit two-flop synchronizer for clock-domain crossings
module sync_2ff (
   input logic clk_i,
   input logic rst_i,
   input logic d_i,
   output logic q_o
);
   logic [1:0] sync_q;
   always_ff @(posedge clk_i)
      sync_q <= rst_i ? 2'b00 : {sync_q[0], d_i};
   assign q_o = sync_q[1];
endmodule

// File: rtl/speed_switch_requester.sv
// speed_switch_requester: snoops KEY1 arming and, on STOP, drives the KEY1 prepare write and
// stalls the CPU until the clock block's disable pulse completes (or low-power stop until wake).
module speed_switch_requester
   import speed_switch_requester_pkg::*;
#(
   parameter logic [15:0] P_KEY1_ADDR = KEY1_ADDR,
   parameter int P_WR_CYCLES = 2,
   parameter int P_TIMEOUT_CYCLES = 1023
) (
   input logic I_CLK,
   input logic I_SYNC_RESET,
   speed_switch_requester_if.slave bus
);
   localparam int TW = $clog2(P_TIMEOUT_CYCLES + 1);
   localparam int WW = $clog2(P_WR_CYCLES + 1);
   state_e state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [WW-1:0] wr_cnt_q, wr_cnt_d;
   logic bus_own_q, bus_own_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0] data_q, data_d;
   logic we_l_q, we_l_d;
   logic stall_q, stall_d;
   logic armed_q, armed_d;
   logic err_q, err_d;
   logic dis_s, snoop_hit, timer_sat;
   sync_2ff u_sync (
      .clk_i(I_CLK),
      .rst_i(I_SYNC_RESET),
      .d_i(bus.I_DISABLE_CONTROLLER),
      .q_o(dis_s)
   );
   assign snoop_hit = !bus.I_CPU_WE_L && bus.I_CPU_ADDR == P_KEY1_ADDR;
   assign timer_sat = timer_q == TW'(P_TIMEOUT_CYCLES);
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      wr_cnt_d = wr_cnt_q;
      bus_own_d = bus_own_q;
      addr_d = addr_q;
      data_d = data_q;
      we_l_d = we_l_q;
      stall_d = stall_q;
      err_d = err_q;
      // the master write must not be mistaken for a CPU arming write
      armed_d = (snoop_hit && state_q != ISSUE_WR) ? bus.I_CPU_WDATA[0] : armed_q;
      case (state_q)
         IDLE:
            if (bus.I_STOP_REQ) begin
               stall_d = 1'b1;
               state_d = armed_q ? ISSUE_WR : STOPPED;
               if (armed_q) begin
                  bus_own_d = 1'b1;
                  addr_d = P_KEY1_ADDR;
                  data_d = KEY1_PREPARE;
                  we_l_d = 1'b0;
                  wr_cnt_d = '0;
               end
            end
         ISSUE_WR: begin
            wr_cnt_d = WW'(wr_cnt_q + 1'b1);
            if (wr_cnt_q == WW'(P_WR_CYCLES - 1)) begin
               we_l_d = 1'b1;
               bus_own_d = 1'b0;
               addr_d = '0;
               data_d = '0;
               timer_d = '0;
               state_d = WAIT_ASSERT;
            end
         end
         WAIT_ASSERT:
            if (dis_s) begin
               state_d = WAIT_DEASSERT;
               timer_d = '0;
            end else if (timer_sat) state_d = FAIL;
            else timer_d = timer_q + 1'b1;
         WAIT_DEASSERT:
            if (!dis_s) state_d = DONE;
            else if (timer_sat) state_d = FAIL;
            else timer_d = timer_q + 1'b1;
         DONE: begin
            armed_d = 1'b0;
            stall_d = 1'b0;
            state_d = IDLE;
         end
         FAIL: begin
            err_d = 1'b1;
            armed_d = 1'b0;
            stall_d = 1'b0;
            state_d = IDLE;
         end
         STOPPED:
            if (bus.I_JOYPAD_WAKE) begin
               stall_d = 1'b0;
               state_d = IDLE;
            end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge I_CLK)
      if (I_SYNC_RESET) begin
         state_q <= IDLE;
         timer_q <= '0;
         wr_cnt_q <= '0;
         bus_own_q <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         we_l_q <= 1'b1;
         stall_q <= 1'b0;
         armed_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         wr_cnt_q <= wr_cnt_d;
         bus_own_q <= bus_own_d;
         addr_q <= addr_d;
         data_q <= data_d;
         we_l_q <= we_l_d;
         stall_q <= stall_d;
         armed_q <= armed_d;
         err_q <= err_d;
      end
   assign bus.O_BUS_OWN = bus_own_q;
   assign bus.O_IOREG_ADDR = addr_q;
   assign bus.O_IOREG_DATA = data_q;
   assign bus.O_IOREG_WE_L = we_l_q;
   assign bus.O_CPU_STALL = stall_q;
   assign bus.O_ARMED = armed_q;
   assign bus.O_SWITCH_DONE = state_q == DONE;
   assign bus.O_TIMEOUT_ERR = err_q;
endmodule

// File: tb/tb_speed_switch_requester.sv
// tb_speed_switch_requester: randomized STOP/KEY1 stimulus scored against a transaction-level model
module tb_speed_switch_requester;
   localparam int WR = 2;
   logic clk = 1'b0;
   logic rst = 1'b1;
   speed_switch_requester_if bus_if();
   speed_switch_requester #(
      .P_KEY1_ADDR(16'hFF4D),
      .P_WR_CYCLES(WR),
      .P_TIMEOUT_CYCLES(1023)
   ) dut (
      .I_CLK(clk),
      .I_SYNC_RESET(rst),
      .bus(bus_if)
   );
   always #5 clk = ~clk;
   typedef struct {
      int writes;
      int dones;
      bit err;
      bit armed;
   } exp_t;
   exp_t exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;
   bit m_armed = 1'b0;
   bit m_err = 1'b0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, req);
      end
   endtask
   // monitor: one expected record per stall release
   int w_we = 0;
   int w_done = 0;
   int w_bad = 0;
   bit prev_stall = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!bus_if.O_IOREG_WE_L) begin
         w_we++;
         if (bus_if.O_IOREG_ADDR !== 16'hFF4D || bus_if.O_IOREG_DATA !== 8'h01 || bus_if.O_BUS_OWN !== 1'b1) w_bad++;
      end
      if (bus_if.O_SWITCH_DONE) begin
         w_done++;
         chk("done_inside_stall", bus_if.O_CPU_STALL, 1);
      end
      if (prev_stall && !bus_if.O_CPU_STALL) begin
         chk("release_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("write_cycles", w_we, e.writes);
            chk("write_addr_data", w_bad, 0);
            chk("done_pulses", w_done, e.dones);
            chk("timeout_err", bus_if.O_TIMEOUT_ERR, e.err);
            chk("armed_after", bus_if.O_ARMED, e.armed);
         end
         w_we = 0;
         w_done = 0;
         w_bad = 0;
      end
      prev_stall = bus_if.O_CPU_STALL;
   end
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic snoop(input logic [15:0] a, input logic [7:0] d);
      bus_if.I_CPU_WE_L = 1'b0;
      bus_if.I_CPU_ADDR = a;
      bus_if.I_CPU_WDATA = d;
      tick();
      bus_if.I_CPU_WE_L = 1'b1;
      if (a == 16'hFF4D) m_armed = d[0];
      chk("armed_snoop", bus_if.O_ARMED, m_armed);
   endtask
   task automatic wait_release(input int budget, output int cycles);
      cycles = 0;
      while (bus_if.O_CPU_STALL && cycles < budget) begin
         tick();
         cycles++;
      end
      chk("release_in_budget", bus_if.O_CPU_STALL, 0);
   endtask
   task automatic do_stop(input bit give_dis, input bit second_stop, input bit same_wr,
                          input logic [7:0] wd, input bit rst_mid, input bit pre_wake);
      exp_t e;
      int c;
      bit armed0;
      armed0 = m_armed;
      if (same_wr && !armed0) m_armed = wd[0];
      if (rst_mid) begin
         m_err = 1'b0;
         m_armed = 1'b0;
         e = '{writes: armed0 ? 1 : 0, dones: 0, err: 1'b0, armed: 1'b0};
      end else if (armed0) begin
         if (!give_dis) m_err = 1'b1;
         m_armed = 1'b0;
         e = '{writes: WR, dones: give_dis ? 1 : 0, err: m_err, armed: 1'b0};
      end else e = '{writes: 0, dones: 0, err: m_err, armed: m_armed};
      exp_q.push_back(e);
      if (pre_wake) bus_if.I_JOYPAD_WAKE = 1'b1;
      bus_if.I_STOP_REQ = 1'b1;
      if (same_wr) begin
         bus_if.I_CPU_WE_L = 1'b0;
         bus_if.I_CPU_ADDR = 16'hFF4D;
         bus_if.I_CPU_WDATA = wd;
      end
      tick();
      bus_if.I_STOP_REQ = 1'b0;
      bus_if.I_CPU_WE_L = 1'b1;
      chk("stall_after_stop", bus_if.O_CPU_STALL, 1);
      if (rst_mid) begin
         rst = 1'b1;
         tick();
         rst = 1'b0;
         chk("rst_bus_own", bus_if.O_BUS_OWN, 0);
         chk("rst_we_l", bus_if.O_IOREG_WE_L, 1);
         chk("rst_stall", bus_if.O_CPU_STALL, 0);
         chk("rst_armed", bus_if.O_ARMED, 0);
      end else if (armed0) begin
         if (give_dis) begin
            tick($urandom_range(3, 8));
            #($urandom_range(0, 7));
            bus_if.I_DISABLE_CONTROLLER = 1'b1;
            tick(8);
            if (second_stop) begin
               bus_if.I_STOP_REQ = 1'b1;
               tick();
               bus_if.I_STOP_REQ = 1'b0;
            end
            tick($urandom_range(8, 14));
            #($urandom_range(0, 7));
            bus_if.I_DISABLE_CONTROLLER = 1'b0;
            wait_release(20, c);
            chk("dis_fall_to_release", c, 4);
         end else wait_release(1100, c);
      end else begin
         if (!pre_wake) begin
            tick($urandom_range(1, 50));
            chk("stopped_no_bus", bus_if.O_BUS_OWN, 0);
            chk("stopped_stall", bus_if.O_CPU_STALL, 1);
            bus_if.I_JOYPAD_WAKE = 1'b1;
         end
         tick();
         chk("wake_release", bus_if.O_CPU_STALL, 0);
      end
      bus_if.I_JOYPAD_WAKE = 1'b0;
      tick(2);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   initial begin
      bus_if.I_CPU_ADDR = '0;
      bus_if.I_CPU_WDATA = '0;
      bus_if.I_CPU_WE_L = 1'b1;
      bus_if.I_STOP_REQ = 1'b0;
      bus_if.I_JOYPAD_WAKE = 1'b0;
      bus_if.I_DISABLE_CONTROLLER = 1'b0;
      tick(3);
      chk("reset_bus_own", bus_if.O_BUS_OWN, 0);
      chk("reset_addr", bus_if.O_IOREG_ADDR, 0);
      chk("reset_data", bus_if.O_IOREG_DATA, 0);
      chk("reset_we_l", bus_if.O_IOREG_WE_L, 1);
      chk("reset_stall", bus_if.O_CPU_STALL, 0);
      chk("reset_armed", bus_if.O_ARMED, 0);
      chk("reset_done", bus_if.O_SWITCH_DONE, 0);
      chk("reset_err", bus_if.O_TIMEOUT_ERR, 0);
      rst = 1'b0;
      tick();
      snoop(16'hFF4D, 8'h01);
      do_stop(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      do_stop(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      snoop(16'hFF4D, 8'h03);
      do_stop(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      snoop(16'hFF4D, 8'hFF);
      do_stop(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      snoop(16'hFF4D, 8'h01);
      do_stop(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      snoop(16'hFF4D, 8'h01);
      do_stop(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      do_stop(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      repeat (25) begin
         repeat ($urandom_range(0, 3))
            snoop($urandom_range(0, 1) ? 16'hFF4D : 16'hFF4D ^ 16'($urandom_range(1, 16'hFFFF)),
                  8'($urandom));
         do_stop(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                 1'b0, $urandom_range(0, 3) == 0);
      end
      tick(5);
      chk("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/speed_switch_requester.md
Name: speed_switch_requester

Overview:
- CPU-side initiator of the CGB KEY1 speed-switch handshake.
- Snoops CPU writes to KEY1 (0xFF4D) and holds bit 0 as an "armed" shadow. It does not forward these writes.
- On STOP: if armed, takes the IO register bus, issues the KEY1 prepare write (0x01), stalls the CPU, and waits for the clock block's disable pulse to rise and fall. Then it releases the CPU.
- If not armed, STOP enters low-power stop until joypad wake.

Parameters:
- P_KEY1_ADDR, 16'hFF4D, IO address of KEY1.
- P_WR_CYCLES, 2, I_CLK cycles the master write strobe is held low.
- P_TIMEOUT_CYCLES, 1023, maximum I_CLK cycles spent waiting in each handshake phase.

Ports:
- I_CLK  in  1  CPU main clock; all logic is on its rising edge.
- I_SYNC_RESET  in  1  synchronous, active-high reset.
- I_CPU_ADDR  in  16  CPU IO address (snooped).
- I_CPU_WDATA  in  8  CPU IO write data (snooped).
- I_CPU_WE_L  in  1  CPU IO write strobe, active low, one cycle per write.
- I_STOP_REQ  in  1  one-cycle pulse when the CPU executes STOP.
- I_JOYPAD_WAKE  in  1  level; any joypad line low.
- I_DISABLE_CONTROLLER  in  1  from the clock block; asynchronous to I_CLK.
- O_BUS_OWN  out  1  high while this block masters the IO register bus (bus mux select).
- O_IOREG_ADDR  out  16  master address.
- O_IOREG_DATA  out  8  master write data.
- O_IOREG_WE_L  out  1  master write strobe, active low.
- O_CPU_STALL  out  1  holds the CPU.
- O_ARMED  out  1  shadow of KEY1 bit 0.
- O_SWITCH_DONE  out  1  one-cycle pulse on successful switch.
- O_TIMEOUT_ERR  out  1  sticky error flag, cleared only by reset.

Behaviour:
- Reset values: state IDLE, O_BUS_OWN 0, O_IOREG_ADDR 0, O_IOREG_DATA 0, O_IOREG_WE_L 1, O_CPU_STALL 0, O_ARMED 0, O_SWITCH_DONE 0, O_TIMEOUT_ERR 0, counters 0, synchronizer flops 0.
- Reset mid-operation: returns to IDLE the next cycle and releases the bus and stall immediately.
- Synchronizer: I_DISABLE_CONTROLLER passes through a 2-flop synchronizer; "dis_s" below is the synchronized value.
- Snoop: when I_CPU_WE_L=0 and I_CPU_ADDR==P_KEY1_ADDR, O_ARMED <= I_CPU_WDATA[0]. This applies in every state except ISSUE_WR.
- States:
  - IDLE: on I_STOP_REQ, set O_CPU_STALL=1 next cycle. Go to ISSUE_WR if O_ARMED is 1 (value registered before this edge; a same-cycle snoop write still updates O_ARMED but does not affect the decision). Otherwise go to STOPPED.
  - ISSUE_WR: O_BUS_OWN=1, O_IOREG_ADDR=P_KEY1_ADDR, O_IOREG_DATA=8'h01, O_IOREG_WE_L=0 for exactly P_WR_CYCLES cycles. Then drive O_IOREG_WE_L=1, O_BUS_OWN=0, go to WAIT_ASSERT, clear the timer.
  - WAIT_ASSERT: when dis_s=1, go to WAIT_DEASSERT and clear the timer. When the timer reaches P_TIMEOUT_CYCLES, go to FAIL.
  - WAIT_DEASSERT: when dis_s=0, go to DONE. Timer timeout goes to FAIL.
  - DONE (1 cycle): O_SWITCH_DONE=1, O_ARMED<=0, O_CPU_STALL<=0, go to IDLE.
  - FAIL (1 cycle): O_TIMEOUT_ERR<=1, O_ARMED<=0, O_CPU_STALL<=0, go to IDLE.
  - STOPPED: O_CPU_STALL=1. On I_JOYPAD_WAKE=1, O_CPU_STALL<=0 and go to IDLE. If wake is already high on entry, exit after 1 cycle.
- I_STOP_REQ is ignored outside IDLE.
- Latency, armed STOP: pulse at edge N gives stall=1 at N+1 and WE_L=0 during N+1..N+P_WR_CYCLES.
- Timer: 10-bit (clog2 of P_TIMEOUT_CYCLES+1). It saturates and never wraps.
- Write-cycle counter: wide enough for P_WR_CYCLES, zeroed on each ISSUE_WR entry.

Decomposition:
- Shared package/defines: KEY1 address (reuse the existing memdef KEY1 define as the parameter default) and the state encodings (IDLE, ISSUE_WR, WAIT_ASSERT, WAIT_DEASSERT, DONE, FAIL, STOPPED; 3-bit).
- One natural sub-module: sync_2ff (generic 1-bit two-flop synchronizer), reusable across clock-domain crossings.

Test Plan:
- Write 0x01 to 0xFF4D, then STOP; model raises disable 5 cycles after the write and holds it 20 cycles -> WE_L low 2 cycles with addr FF4D / data 01; stall high throughout; O_SWITCH_DONE pulses once, 2–3 cycles after disable falls; O_ARMED=0; no error.
- STOP with O_ARMED=0 -> no bus activity, stall=1; raise I_JOYPAD_WAKE after 50 cycles -> stall=0 next cycle.
- Armed STOP and disable never rises -> after 1023 cycles in WAIT_ASSERT, O_TIMEOUT_ERR=1 (sticky), stall=0, O_ARMED=0.
- Write 0x00 to KEY1 in the same cycle as I_STOP_REQ while armed -> switch sequence still runs (old armed value used).
- A second I_STOP_REQ during WAIT_DEASSERT -> ignored, exactly one O_SWITCH_DONE pulse.
- I_SYNC_RESET asserted during ISSUE_WR -> next cycle O_BUS_OWN=0, WE_L=1, stall=0, O_ARMED=0, state IDLE.
